// File: rtl/soc_top.sv
// soc_top: minimal RV32I SoC -- one multi-cycle core, one word-organised RAM
// (instance RAM, array MEM) and one memory-mapped LED register at 0x8000_0000.
// Optional build macro SOC_HALT_ON_EBREAK_EN: ECALL/EBREAK stop the core and
// raise HALT; without it they execute as NOPs and HALT is tied low.

module soc_ram #(
    parameter int RAM_SIZE = 'h600
) (
    input  logic        clk,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    localparam int AW = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;

    logic [31:0]   MEM [0:RAM_SIZE-1];
    logic          in_range;
    logic [AW-1:0] word_idx;

    assign in_range = (addr[31] == 1'b0) && ({2'b00, addr[31:2]} < 32'(RAM_SIZE));
    assign word_idx = addr[AW+1:2];

    // Synchronous read with one cycle of latency; out-of-range words read as zero
    always_ff @(posedge clk) begin
        rdata <= in_range ? MEM[word_idx] : 32'h0;
    end

    // Byte-enabled write; out-of-range writes are dropped
    always_ff @(posedge clk) begin
        if (we && in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    MEM[word_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end
endmodule

module soc_top #(
    parameter int XLEN     = 32,
    parameter int RAM_SIZE = 'h600
) (
    input  logic       CLK,
    input  logic       RESETn,
    output logic [7:0] LEDS,
    output logic       HALT
);
    if (XLEN != 32) begin : g_bad_xlen
        $error("soc_top: only XLEN=32 is supported");
    end

    typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, LOAD, HALTED} state_t;

    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OPIMM  = 7'h13;
    localparam logic [6:0] OPC_OP     = 7'h33;
`ifdef SOC_HALT_ON_EBREAK_EN
    localparam logic [6:0]  OPC_SYSTEM = 7'h73;
    localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;
`endif

    state_t      state, next_state;
    logic [31:0] pc, next_pc;
    logic [31:0] ir, rs1_val, rs2_val;
    logic [31:0] regs [0:31];

    logic [31:0] ram_addr, ram_rdata;
    logic        ram_we;
    logic        leds_we;
    logic        rf_we;
    logic [31:0] rf_wdata;

    logic [1:0]  ld_off_q;
    logic        ld_io_q;
    logic [31:0] io_rdata_q;

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1_idx, rs2_idx;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] op_b, alu_result, ls_addr;
    logic        branch_taken, is_leds;
    logic [3:0]  st_mask, st_be;
    logic [31:0] st_wdata, ld_word, ld_aligned, load_data;

    function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] sh);
        logic [63:0] t;
        t = {x, x} << sh;
        return t[63:32];
    endfunction

    function automatic logic [31:0] rotr32(input logic [31:0] x, input logic [4:0] sh);
        logic [63:0] t;
        t = {x, x} >> sh;
        return t[31:0];
    endfunction

    function automatic logic [3:0] rotl4(input logic [3:0] x, input logic [1:0] sh);
        logic [7:0] t;
        t = {x, x} << sh;
        return t[7:4];
    endfunction

    assign opcode  = ir[6:0];
    assign rd      = ir[11:7];
    assign funct3  = ir[14:12];
    assign rs1_idx = ram_rdata[19:15];
    assign rs2_idx = ram_rdata[24:20];

    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u = {ir[31:12], 12'h000};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    // Data address for loads/stores; only low two bits steer lanes within a word
    assign ls_addr  = rs1_val + ((opcode == OPC_STORE) ? imm_s : imm_i);
    assign is_leds  = (ls_addr[31:2] == 30'h2000_0000);
    assign st_mask  = (funct3[1:0] == 2'd0) ? 4'b0001 :
                      (funct3[1:0] == 2'd1) ? 4'b0011 : 4'b1111;
    assign st_be    = rotl4(st_mask, ls_addr[1:0]);
    assign st_wdata = rotl32(rs2_val, {ls_addr[1:0], 3'b000});
    assign op_b     = (opcode == OPC_OP) ? rs2_val : imm_i;
    assign ram_addr = (state == EXECUTE) ? ls_addr : pc;

    // ALU for OP and OP-IMM; SUB only exists in the register form
    always_comb begin
        alu_result = 32'h0;
        case (funct3)
            3'd0: alu_result = (opcode == OPC_OP && ir[30]) ? rs1_val - op_b : rs1_val + op_b;
            3'd1: alu_result = rs1_val << op_b[4:0];
            3'd2: alu_result = {31'b0, $signed(rs1_val) < $signed(op_b)};
            3'd3: alu_result = {31'b0, rs1_val < op_b};
            3'd4: alu_result = rs1_val ^ op_b;
            3'd5: alu_result = ir[30] ? 32'($signed(rs1_val) >>> op_b[4:0]) : rs1_val >> op_b[4:0];
            3'd6: alu_result = rs1_val | op_b;
            default: alu_result = rs1_val & op_b;
        endcase
    end

    // Branch condition evaluation
    always_comb begin
        branch_taken = 1'b0;
        case (funct3)
            3'd0: branch_taken = (rs1_val == rs2_val);
            3'd1: branch_taken = (rs1_val != rs2_val);
            3'd4: branch_taken = ($signed(rs1_val) <  $signed(rs2_val));
            3'd5: branch_taken = ($signed(rs1_val) >= $signed(rs2_val));
            3'd6: branch_taken = (rs1_val <  rs2_val);
            3'd7: branch_taken = (rs1_val >= rs2_val);
            default: branch_taken = 1'b0;
        endcase
    end

    // Load return: rotate the addressed byte to lane 0, then extend by size
    always_comb begin
        ld_word    = ld_io_q ? io_rdata_q : ram_rdata;
        ld_aligned = rotr32(ld_word, {ld_off_q, 3'b000});
        case (funct3)
            3'd0:    load_data = {{24{ld_aligned[7]}}, ld_aligned[7:0]};
            3'd1:    load_data = {{16{ld_aligned[15]}}, ld_aligned[15:0]};
            3'd4:    load_data = {24'h0, ld_aligned[7:0]};
            3'd5:    load_data = {16'h0, ld_aligned[15:0]};
            default: load_data = ld_aligned;
        endcase
    end

    // Next-state, next-PC and write strobes for the multi-cycle sequence
    always_comb begin
        next_state = state;
        next_pc    = pc;
        rf_we      = 1'b0;
        rf_wdata   = 32'h0;
        ram_we     = 1'b0;
        leds_we    = 1'b0;
        case (state)
            FETCH:  next_state = DECODE;
            DECODE: next_state = EXECUTE;
            EXECUTE: begin
                next_state = FETCH;
                next_pc    = pc + 32'd4;
                case (opcode)
                    OPC_LUI:   begin rf_we = 1'b1; rf_wdata = imm_u; end
                    OPC_AUIPC: begin rf_we = 1'b1; rf_wdata = pc + imm_u; end
                    OPC_JAL: begin
                        rf_we    = 1'b1;
                        rf_wdata = pc + 32'd4;
                        next_pc  = pc + imm_j;
                    end
                    OPC_JALR: begin
                        rf_we    = 1'b1;
                        rf_wdata = pc + 32'd4;
                        next_pc  = (rs1_val + imm_i) & 32'hFFFF_FFFE;
                    end
                    OPC_BRANCH: if (branch_taken) next_pc = pc + imm_b;
                    OPC_LOAD:   next_state = LOAD;
                    OPC_STORE: begin
                        ram_we  = ~ls_addr[31];
                        leds_we = is_leds & st_be[0];
                    end
                    OPC_OPIMM, OPC_OP: begin rf_we = 1'b1; rf_wdata = alu_result; end
`ifdef SOC_HALT_ON_EBREAK_EN
                    OPC_SYSTEM: begin
                        if (ir == INSN_ECALL || ir == INSN_EBREAK) begin
                            next_state = HALTED;
                            next_pc    = pc;
                        end
                    end
`endif
                    default: ;
                endcase
            end
            LOAD: begin
                rf_we      = 1'b1;
                rf_wdata   = load_data;
                next_state = FETCH;
            end
            HALTED:  next_state = HALTED;
            default: next_state = FETCH;
        endcase
    end

    // FSM, PC, LED register, instruction latch and load bookkeeping
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state      <= FETCH;
            pc         <= 32'h0;
            LEDS       <= 8'h0;
            ir         <= 32'h0;
            rs1_val    <= 32'h0;
            rs2_val    <= 32'h0;
            ld_off_q   <= 2'd0;
            ld_io_q    <= 1'b0;
            io_rdata_q <= 32'h0;
        end else begin
            state <= next_state;
            pc    <= next_pc;
            if (leds_we) LEDS <= st_wdata[7:0];
            if (state == DECODE) begin
                ir      <= ram_rdata;
                rs1_val <= (rs1_idx == 5'd0) ? 32'h0 : regs[rs1_idx];
                rs2_val <= (rs2_idx == 5'd0) ? 32'h0 : regs[rs2_idx];
            end
            if (state == EXECUTE) begin
                ld_off_q   <= ls_addr[1:0];
                ld_io_q    <= ls_addr[31];
                io_rdata_q <= is_leds ? {24'h0, LEDS} : 32'h0;
            end
        end
    end

    // Register file write port; x0 writes are discarded, contents are not reset
    always_ff @(posedge CLK) begin
        if (rf_we && rd != 5'd0) regs[rd] <= rf_wdata;
    end

    soc_ram #(.RAM_SIZE(RAM_SIZE)) RAM (
        .clk   (CLK),
        .addr  (ram_addr),
        .we    (ram_we),
        .be    (st_be),
        .wdata (st_wdata),
        .rdata (ram_rdata)
    );

`ifdef SOC_HALT_ON_EBREAK_EN
    assign HALT = (state == HALTED);
`else
    assign HALT = 1'b0;
`endif
endmodule

// File: tb/tb_soc_top.sv
// tb_soc_top: directed self-checking bench for soc_top; programs are preloaded
// into dut.RAM.MEM while reset is held, then the core runs freely.

module tb_soc_top;
    localparam int RAM_WORDS = 'h600;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic [7:0] leds;
    logic       halt;
    int         errors = 0;
    int         checks = 0;

    soc_top dut (
        .CLK    (clk),
        .RESETn (reset_n),
        .LEDS   (leds),
        .HALT   (halt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_lui(input logic [19:0] imm, input logic [4:0] rd);
        return {imm, rd, 7'h37};
    endfunction

    // Hold the core in reset and wipe the RAM so stray words decode as NOPs
    task automatic hold_reset_and_clear();
        @(negedge clk);
        reset_n = 1'b0;
        for (int i = 0; i < RAM_WORDS; i++) dut.RAM.MEM[i] = 32'h0;
    endtask

    // Release reset between edges and let the program run for n cycles
    task automatic release_and_run(input int n);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic load_sum_loop();
        dut.RAM.MEM[0]     = enc_i(12'd0, 5'd0, 3'd0, 5'd1, 7'h13);
        dut.RAM.MEM[1]     = enc_i(12'd1, 5'd0, 3'd0, 5'd2, 7'h13);
        dut.RAM.MEM[2]     = enc_i(12'd11, 5'd0, 3'd0, 5'd4, 7'h13);
        dut.RAM.MEM[3]     = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd1);
        dut.RAM.MEM[4]     = enc_i(12'd1, 5'd2, 3'd0, 5'd2, 7'h13);
        dut.RAM.MEM[5]     = enc_b(13'h1FF8, 5'd4, 5'd2, 3'd1);
        dut.RAM.MEM[6]     = enc_lui(20'h80000, 5'd3);
        dut.RAM.MEM[7]     = enc_s(12'd0, 5'd1, 5'd3, 3'd0);
        dut.RAM.MEM[8]     = enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd0);
        dut.RAM.MEM[9]     = enc_s(12'h400, 5'd0, 5'd0, 3'd2);
        dut.RAM.MEM[10]    = 32'h0000_006F;
        dut.RAM.MEM['h100] = 32'hDEAD_BEEF;
    endtask

    task automatic test_reset();
        #3 reset_n = 1'b0;
        #1;
        if (leds !== 8'h00) begin errors++; $display("[TB] FAIL reset_leds: got %h expected %h", leds, 8'h00); end
        checks++;
        if (halt !== 1'b0) begin errors++; $display("[TB] FAIL reset_halt: got %b expected %b", halt, 1'b0); end
        checks++;
        if (dut.pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected %h", dut.pc, 32'h0); end
        checks++;
    endtask

    task automatic test_led_store();
        hold_reset_and_clear();
        dut.RAM.MEM[0] = 32'h02A0_0093;
        dut.RAM.MEM[1] = 32'h8000_01B7;
        dut.RAM.MEM[2] = 32'h0011_8023;
        dut.RAM.MEM[3] = 32'h0000_006F;
        release_and_run(10);
        if (leds !== 8'h2A) begin errors++; $display("[TB] FAIL led_store: got %h expected %h", leds, 8'h2A); end
        checks++;
        repeat (20) @(negedge clk);
        if (leds !== 8'h2A) begin errors++; $display("[TB] FAIL led_hold: got %h expected %h", leds, 8'h2A); end
        checks++;
        if (dut.pc !== 32'hC) begin errors++; $display("[TB] FAIL led_loop_pc: got %h expected %h", dut.pc, 32'hC); end
        checks++;
        if (halt !== 1'b0) begin errors++; $display("[TB] FAIL led_halt: got %b expected %b", halt, 1'b0); end
        checks++;
    endtask

    task automatic test_load_store();
        logic [31:0] exp_mem [0:7];
        hold_reset_and_clear();
        dut.RAM.MEM['h100] = 32'h8000_00F0;
        dut.RAM.MEM['h107] = 32'h1122_3344;
        dut.RAM.MEM[0]  = enc_i(12'h400, 5'd0, 3'd0, 5'd2, 7'h13);
        dut.RAM.MEM[1]  = enc_i(12'd0, 5'd2, 3'd0, 5'd5, 7'h03);
        dut.RAM.MEM[2]  = enc_i(12'd0, 5'd2, 3'd4, 5'd6, 7'h03);
        dut.RAM.MEM[3]  = enc_i(12'd0, 5'd2, 3'd1, 5'd7, 7'h03);
        dut.RAM.MEM[4]  = enc_i(12'd0, 5'd2, 3'd5, 5'd8, 7'h03);
        dut.RAM.MEM[5]  = enc_i(12'd0, 5'd2, 3'd2, 5'd9, 7'h03);
        dut.RAM.MEM[6]  = enc_s(12'd4, 5'd9, 5'd2, 3'd2);
        dut.RAM.MEM[7]  = enc_s(12'd8, 5'd5, 5'd2, 3'd2);
        dut.RAM.MEM[8]  = enc_s(12'd12, 5'd6, 5'd2, 3'd2);
        dut.RAM.MEM[9]  = enc_s(12'd16, 5'd7, 5'd2, 3'd2);
        dut.RAM.MEM[10] = enc_s(12'd20, 5'd8, 5'd2, 3'd2);
        dut.RAM.MEM[11] = enc_i(12'd3, 5'd2, 3'd1, 5'd10, 7'h03);
        dut.RAM.MEM[12] = enc_s(12'd24, 5'd10, 5'd2, 3'd2);
        dut.RAM.MEM[13] = enc_s(12'd31, 5'd6, 5'd2, 3'd1);
        dut.RAM.MEM[14] = 32'h0000_006F;
        exp_mem = '{32'h8000_00F0, 32'h8000_00F0, 32'hFFFF_FFF0, 32'h0000_00F0,
                    32'h0000_00F0, 32'h0000_00F0, 32'hFFFF_F080, 32'hF022_3300};
        release_and_run(80);
        for (int i = 0; i < 8; i++) begin
            if (dut.RAM.MEM['h100 + i] !== exp_mem[i]) begin
                errors++;
                $display("[TB] FAIL ldst_word%0d: got %h expected %h", i, dut.RAM.MEM['h100 + i], exp_mem[i]);
            end
            checks++;
        end
    endtask

    task automatic test_branch_loop();
        hold_reset_and_clear();
        load_sum_loop();
        release_and_run(150);
        if (leds !== 8'h37) begin errors++; $display("[TB] FAIL loop_sum: got %h expected %h", leds, 8'h37); end
        checks++;
        if (dut.RAM.MEM['h100] !== 32'h0) begin
            errors++; $display("[TB] FAIL loop_x0: got %h expected %h", dut.RAM.MEM['h100], 32'h0);
        end
        checks++;
    endtask

    task automatic test_alu_corners();
        logic [31:0] exp_alu [0:4];
        hold_reset_and_clear();
        for (int i = 0; i < 5; i++) dut.RAM.MEM['h100 + i] = 32'hA5A5_A5A5;
        dut.RAM.MEM[0]  = enc_i(12'hFFF, 5'd0, 3'd0, 5'd1, 7'h13);
        dut.RAM.MEM[1]  = enc_i(12'd1, 5'd0, 3'd0, 5'd2, 7'h13);
        dut.RAM.MEM[2]  = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);
        dut.RAM.MEM[3]  = enc_lui(20'h80000, 5'd4);
        dut.RAM.MEM[4]  = enc_i(12'd31, 5'd0, 3'd0, 5'd5, 7'h13);
        dut.RAM.MEM[5]  = enc_r(7'h20, 5'd5, 5'd4, 3'd5, 5'd6);
        dut.RAM.MEM[6]  = enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd7);
        dut.RAM.MEM[7]  = enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd8);
        dut.RAM.MEM[8]  = enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd9);
        dut.RAM.MEM[9]  = enc_s(12'h400, 5'd3, 5'd0, 3'd2);
        dut.RAM.MEM[10] = enc_s(12'h404, 5'd6, 5'd0, 3'd2);
        dut.RAM.MEM[11] = enc_s(12'h408, 5'd7, 5'd0, 3'd2);
        dut.RAM.MEM[12] = enc_s(12'h40C, 5'd8, 5'd0, 3'd2);
        dut.RAM.MEM[13] = enc_s(12'h410, 5'd9, 5'd0, 3'd2);
        dut.RAM.MEM[14] = 32'h0000_006F;
        exp_alu = '{32'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h2};
        release_and_run(60);
        for (int i = 0; i < 5; i++) begin
            if (dut.RAM.MEM['h100 + i] !== exp_alu[i]) begin
                errors++;
                $display("[TB] FAIL alu_result%0d: got %h expected %h", i, dut.RAM.MEM['h100 + i], exp_alu[i]);
            end
            checks++;
        end
    endtask

    task automatic test_async_reset();
        hold_reset_and_clear();
        load_sum_loop();
        release_and_run(150);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        if (leds !== 8'h00) begin errors++; $display("[TB] FAIL areset_leds: got %h expected %h", leds, 8'h00); end
        checks++;
        if (dut.pc !== 32'h0) begin errors++; $display("[TB] FAIL areset_pc: got %h expected %h", dut.pc, 32'h0); end
        checks++;
        release_and_run(40);
        #2 reset_n = 1'b0;
        #1;
        if (dut.pc !== 32'h0) begin errors++; $display("[TB] FAIL areset_midloop_pc: got %h expected %h", dut.pc, 32'h0); end
        checks++;
        release_and_run(150);
        if (leds !== 8'h37) begin errors++; $display("[TB] FAIL areset_rerun: got %h expected %h", leds, 8'h37); end
        checks++;
    endtask

    task automatic test_ebreak();
        hold_reset_and_clear();
        dut.RAM.MEM[0] = enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'h13);
        dut.RAM.MEM[1] = enc_lui(20'h80000, 5'd3);
        dut.RAM.MEM[2] = enc_s(12'd0, 5'd1, 5'd3, 3'd0);
        dut.RAM.MEM[3] = enc_i(12'd9, 5'd0, 3'd0, 5'd1, 7'h13);
        dut.RAM.MEM[4] = 32'h0010_0073;
        dut.RAM.MEM[5] = enc_s(12'd0, 5'd1, 5'd3, 3'd0);
        dut.RAM.MEM[6] = enc_s(12'h400, 5'd1, 5'd0, 3'd2);
        dut.RAM.MEM[7] = 32'h0000_006F;
        release_and_run(50);
`ifdef SOC_HALT_ON_EBREAK_EN
        if (halt !== 1'b1) begin errors++; $display("[TB] FAIL ebreak_halt: got %b expected %b", halt, 1'b1); end
        checks++;
        if (leds !== 8'h05) begin errors++; $display("[TB] FAIL ebreak_leds: got %h expected %h", leds, 8'h05); end
        checks++;
        if (dut.pc !== 32'h10) begin errors++; $display("[TB] FAIL ebreak_pc: got %h expected %h", dut.pc, 32'h10); end
        checks++;
        if (dut.RAM.MEM['h100] !== 32'h0) begin
            errors++; $display("[TB] FAIL ebreak_nowrite: got %h expected %h", dut.RAM.MEM['h100], 32'h0);
        end
        checks++;
`else
        if (halt !== 1'b0) begin errors++; $display("[TB] FAIL ebreak_halt: got %b expected %b", halt, 1'b0); end
        checks++;
        if (leds !== 8'h09) begin errors++; $display("[TB] FAIL ebreak_leds: got %h expected %h", leds, 8'h09); end
        checks++;
        if (dut.pc !== 32'h1C) begin errors++; $display("[TB] FAIL ebreak_pc: got %h expected %h", dut.pc, 32'h1C); end
        checks++;
        if (dut.RAM.MEM['h100] !== 32'h9) begin
            errors++; $display("[TB] FAIL ebreak_store: got %h expected %h", dut.RAM.MEM['h100], 32'h9);
        end
        checks++;
`endif
    endtask

    initial begin
        $display("[TB] soc_top directed tests start");
        test_reset();
        test_led_store();
        test_load_store();
        test_branch_loop();
        test_alu_corners();
        test_async_reset();
        test_ebreak();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
